count_tick_gen: RTL and testbench

- Upstream stage for the down-counter family: one-cycle clock-enable `tick` pulses, so counters run on the single system clock instead of a divided clock.
- Tick rate is selected from switches.
- Run/pause switch and a debounced single-step button support hand-stepping a counter on the board LEDs.
- Instantiated in the lab top level between the board clock and the counter under test.

---
 rtl/count_tick_gen.sv | 156 +++++++++++++++
 tb/tb_count_tick_gen.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/count_tick_gen.sv
// count_tick_gen: single-clock tick generator for the down-counter family.
// Emits one-cycle clock-enable pulses at a switch-selected power-of-two
// rate. A run/pause switch and a debounced single-step button allow the
// counter to be hand-stepped.
// Optional feature macro: TICK_HEARTBEAT_EN. When it is defined, heartbeat
// toggles on every tick. When it is undefined, heartbeat is tied low.
module count_tick_gen #(
  parameter int CNT_W     = 32,
  parameter int DB_CYCLES = 1000000,
  parameter int DB_W      = 20,
  parameter int TOT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rate_sel,
  input  logic             run_sw,
  input  logic             step_btn,
  output logic             tick,
  output logic             running,
  output logic [TOT_W-1:0] tick_total,
  output logic             heartbeat
);

  typedef enum logic [1:0] {PAUSED = 2'd0, RUN = 2'd1, STEP = 2'd2} state_t;

  logic [CNT_W-1:0] presc_q, presc_d;
  logic [4:0]       rate_q;
  logic [CNT_W-1:0] mask;
  logic             tick_raw;

  logic             run_s1_q, run_s_q;
  logic             step_s1_q, step_s_q;

  logic [DB_W-1:0]  db_cnt_q, db_cnt_d;
  logic             db_lvl_q, db_lvl_d;
  logic             db_prev_q;
  logic             step_pulse;

  state_t           state_q;
  logic             tick_q, running_q;
  logic [TOT_W-1:0] total_q;

  // Free-running prescaler and a registered copy of the rate switches
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      rate_q  <= '0;
    end else begin
      presc_q <= presc_d;
      rate_q  <= rate_sel;
    end
  end

  assign presc_d = presc_q + CNT_W'(1);

  // Low-bit mask [k:0]; a rate above CNT_W-1 naturally saturates to all-ones
  always_comb begin
    mask = '0;
    for (int i = 0; i < CNT_W; i++) mask[i] = (i <= int'(rate_q));
  end

  assign tick_raw = ((presc_q & mask) == mask);

  // Two-flop synchronizers for the asynchronous switch and button
  always_ff @(posedge clk) begin
    if (rst) begin
      run_s1_q  <= 1'b0;
      run_s_q   <= 1'b0;
      step_s1_q <= 1'b0;
      step_s_q  <= 1'b0;
    end else begin
      run_s1_q  <= run_sw;
      run_s_q   <= run_s1_q;
      step_s1_q <= step_btn;
      step_s_q  <= step_s1_q;
    end
  end

  // Debounce: count consecutive cycles where the input disagrees with the
  // accepted level. Any return to agreement restarts the count. After
  // DB_CYCLES disagreeing cycles in a row, the new level is accepted.
  always_comb begin
    db_cnt_d = '0;
    db_lvl_d = db_lvl_q;
    if (step_s_q != db_lvl_q) begin
      if (db_cnt_q == DB_W'(DB_CYCLES - 1)) begin
        db_lvl_d = step_s_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  // Debounce state and the previous level, used for rising-edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q  <= '0;
      db_lvl_q  <= 1'b0;
      db_prev_q <= 1'b0;
    end else begin
      db_cnt_q  <= db_cnt_d;
      db_lvl_q  <= db_lvl_d;
      db_prev_q <= db_lvl_q;
    end
  end

  assign step_pulse = db_lvl_q & ~db_prev_q;

  // Run/pause/step FSM with the registered tick and running outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= PAUSED;
      tick_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      tick_q    <= ((state_q == RUN) && tick_raw) || (state_q == STEP);
      running_q <= (state_q == RUN);
      case (state_q)
        PAUSED: begin
          // run has priority; a coincident step is dropped
          if (run_s_q)         state_q <= RUN;
          else if (step_pulse) state_q <= STEP;
        end
        RUN:     if (!run_s_q) state_q <= PAUSED;
        STEP:    state_q <= PAUSED;
        default: state_q <= PAUSED;
      endcase
    end
  end

  // Wrapping count of emitted ticks
  always_ff @(posedge clk) begin
    if (rst) total_q <= '0;
    else     total_q <= total_q + TOT_W'(tick_q);
  end

`ifdef TICK_HEARTBEAT_EN
  logic hb_q;

  // LED blink at half the tick rate
  always_ff @(posedge clk) begin
    if (rst)         hb_q <= 1'b0;
    else if (tick_q) hb_q <= ~hb_q;
  end

  assign heartbeat = hb_q;
`else
  assign heartbeat = 1'b0;
`endif

  assign tick       = tick_q;
  assign running    = running_q;
  assign tick_total = total_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Bench for count_tick_gen: directed scenarios followed by a random phase.
// A cycle-level reference model is compared against the DUT on every clock.
module tb_count_tick_gen;
  localparam int CNT_W = 8, DB_CYCLES = 4, DB_W = 3, TOT_W = 4;
  localparam int P = 0, R = 1, S = 2;
`ifdef TICK_HEARTBEAT_EN
  localparam int HB_EN = 1;
`else
  localparam int HB_EN = 0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [4:0] rate_sel = '0;
  logic run_sw = 1'b0, step_btn = 1'b0;
  logic tick, running, heartbeat;
  logic [TOT_W-1:0] tick_total;

  count_tick_gen #(.CNT_W(CNT_W), .DB_CYCLES(DB_CYCLES), .DB_W(DB_W), .TOT_W(TOT_W)) dut (
    .clk(clk), .rst(rst), .rate_sel(rate_sel), .run_sw(run_sw), .step_btn(step_btn),
    .tick(tick), .running(running), .tick_total(tick_total), .heartbeat(heartbeat)
  );

  always #5 clk = ~clk;

  int total_n = 0, bad_n = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_n++;
    if (got !== exp) begin
      bad_n++;
      $display("FAIL %s: got %0d want %0d", tag, got, exp);
    end
  endtask

  // Reference model state: time since reset, input delay lines, accepted
  // button level, and the run/pause/step mode.
  int m_age, m_rate, m_lvl, m_lvl_old, m_diff, m_mode, m_tick, m_run, m_total, m_hb;
  int m_run_h[2], m_step_h[2];

  task automatic model_edge();
    int k, per, raw, pulse, run_s, step_s, nmode;
    if (rst) begin
      m_age = 0; m_rate = 0; m_lvl = 0; m_lvl_old = 0; m_diff = 0; m_mode = P;
      m_tick = 0; m_run = 0; m_total = 0; m_hb = 0;
      m_run_h = '{0, 0}; m_step_h = '{0, 0};
    end else begin
      k      = (m_rate > CNT_W - 1) ? CNT_W - 1 : m_rate;
      per    = 1 << (k + 1);
      raw    = (((m_age % (1 << CNT_W)) % per) == per - 1);
      run_s  = m_run_h[1];
      step_s = m_step_h[1];
      pulse  = (m_lvl == 1 && m_lvl_old == 0);
      if (HB_EN != 0 && m_tick != 0) m_hb = 1 - m_hb;
      m_total = (m_total + m_tick) % (1 << TOT_W);
      m_tick  = ((m_mode == R && raw != 0) || m_mode == S) ? 1 : 0;
      m_run   = (m_mode == R) ? 1 : 0;
      case (m_mode)
        P:       nmode = run_s ? R : (pulse ? S : P);
        R:       nmode = run_s ? R : P;
        default: nmode = P;
      endcase
      m_mode    = nmode;
      m_lvl_old = m_lvl;
      if (step_s == m_lvl) m_diff = 0;
      else if (m_diff == DB_CYCLES - 1) begin m_lvl = step_s; m_diff = 0; end
      else m_diff++;
      m_run_h[1]  = m_run_h[0];  m_run_h[0]  = int'(run_sw);
      m_step_h[1] = m_step_h[0]; m_step_h[0] = int'(step_btn);
      m_rate = int'(rate_sel);
      m_age++;
    end
  endtask

  // One clock: model follows the edge, outputs compared at the falling edge
  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("tick", tick, m_tick);
    chk("running", running, m_run);
    chk("total", tick_total, m_total);
    chk("hb", heartbeat, m_hb);
  endtask

  task automatic wait_tick(input string tag, input int limit, output int n);
    n = 0;
    do begin cyc(); n++; end while (tick !== 1'b1 && n < limit);
    if (tick !== 1'b1) chk(tag, tick, 1);
  endtask

  initial begin
    int n, cnt, snap, seen;
    // reset
    rst = 1'b1;
    repeat (3) cyc();
    chk("rst_tick", tick, 0);
    chk("rst_running", running, 0);
    chk("rst_total", tick_total, 0);
    chk("rst_hb", heartbeat, 0);

    // free-run at rate 2: period 8
    rst = 1'b0; run_sw = 1'b1; rate_sel = 5'd2;
    n = 0;
    do begin cyc(); n++; end while (running !== 1'b1 && n < 10);
    chk("run_lat", (n >= 3 && n <= 4), 1);
    seen = (tick === 1'b1) ? 1 : 0;
    while (seen < 5) begin
      wait_tick("run_tmo", 20, n);
      if (seen > 0) chk("per8", n, 8);
      seen++;
    end
    cyc();
    chk("total5", tick_total, 5);
    chk("hb5", heartbeat, HB_EN);

    // pause mid-period
    repeat ($urandom_range(1, 6)) cyc();
    run_sw = 1'b0; cnt = 0;
    repeat (10) begin cyc(); cnt += int'(tick); end
    chk("pause_le1", (cnt <= 1), 1);
    chk("pause_running", running, 0);
    snap = int'(tick_total); cnt = 0;
    repeat (20) begin cyc(); cnt += int'(tick); end
    chk("pause_noticks", cnt, 0);
    chk("pause_frozen", tick_total, snap);

    // bouncy press while paused -> one step; release -> nothing
    snap = int'(tick_total); cnt = 0;
    for (int i = 0; i < 10; i++) begin step_btn = ~step_btn; cyc(); cnt += int'(tick); end
    step_btn = 1'b1;
    repeat (10) begin cyc(); cnt += int'(tick); end
    chk("bounce_one", cnt, 1);
    chk("bounce_total", tick_total, (snap + 1) % (1 << TOT_W));
    step_btn = 1'b0; cnt = 0;
    repeat (20) begin cyc(); cnt += int'(tick); end
    chk("release_none", cnt, 0);

    // press during RUN leaves the period alone
    run_sw = 1'b1;
    wait_tick("srun_sync", 30, n);
    step_btn = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_tick("srun_tmo", 20, n);
      chk("srun_per8", n, 8);
      if (i == 1) step_btn = 1'b0;
    end

    // rate 2 -> 0: period 2 within 3 cycles
    wait_tick("r0_sync", 20, n);
    rate_sel = 5'd0;
    wait_tick("r0_first", 3, n);
    for (int i = 0; i < 5; i++) begin
      wait_tick("r0_tmo", 4, n);
      chk("per2", n, 2);
    end

    // clamp: rate 31 with CNT_W=8 -> period 256
    rate_sel = 5'd31;
    wait_tick("clamp_sync", 300, n);
    for (int i = 0; i < 2; i++) begin
      wait_tick("clamp_tmo", 300, n);
      chk("per256", n, 256);
    end

    // reset on the cycle the FSM sits in STEP
    rate_sel = 5'd2; run_sw = 1'b0;
    repeat (8) cyc();
    step_btn = 1'b1; n = 0;
    while (m_mode != S && n < 30) begin cyc(); n++; end
    chk("step_reach", m_mode, S);
    rst = 1'b1;
    cyc();
    chk("midrst_tick", tick, 0);
    chk("midrst_total", tick_total, 0);
    chk("midrst_hb", heartbeat, 0);
    rst = 1'b0; step_btn = 1'b0;
    repeat (5) cyc();

    // random phase
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 59) == 0) run_sw = ~run_sw;
      if ($urandom_range(0, 7) == 0) step_btn = $urandom_range(0, 1) != 0;
      if ($urandom_range(0, 199) == 0)
        rate_sel = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 3));
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total_n, bad_n);
    $finish;
  end
endmodule
